// File: rtl/ex_operand_stage.sv
// ID/EX register feeding the ALU: operand select,
// forwarding, load-use bubbles and valid/ready handshake.
package toothless_pkg;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_XOR  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_AND  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_opcode_e;
endpackage

module ex_operand_stage
  import toothless_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      flush_i,
  input  logic                      id_valid_i,
  output logic                      id_ready_o,
  input  alu_opcode_e               id_alu_op_i,
  input  logic [DATA_WIDTH-1:0]     id_pc_i,
  input  logic [DATA_WIDTH-1:0]     id_imm_i,
  input  logic                      id_use_pc_i,
  input  logic                      id_use_imm_i,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr_i,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr_i,
  input  logic [DATA_WIDTH-1:0]     id_rs1_data_i,
  input  logic [DATA_WIDTH-1:0]     id_rs2_data_i,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd_addr_i,
  input  logic                      id_rd_we_i,
  input  logic                      mem_rd_we_i,
  input  logic [REG_ADDR_WIDTH-1:0] mem_rd_addr_i,
  input  logic [DATA_WIDTH-1:0]     mem_rd_data_i,
  input  logic                      mem_data_valid_i,
  input  logic                      wb_rd_we_i,
  input  logic [REG_ADDR_WIDTH-1:0] wb_rd_addr_i,
  input  logic [DATA_WIDTH-1:0]     wb_rd_data_i,
  output logic                      ex_valid_o,
  input  logic                      ex_ready_i,
  output alu_opcode_e               alu_operator_o,
  output logic [DATA_WIDTH-1:0]     alu_operand_a_o,
  output logic [DATA_WIDTH-1:0]     alu_operand_b_o,
  output logic [REG_ADDR_WIDTH-1:0] ex_rd_addr_o,
  output logic                      ex_rd_we_o,
  output logic [CNT_WIDTH-1:0]      stall_cnt_o
);

  typedef struct packed {
    alu_opcode_e               alu_op;
    logic [DATA_WIDTH-1:0]     pc;
    logic [DATA_WIDTH-1:0]     imm;
    logic [DATA_WIDTH-1:0]     rs1_data;
    logic [DATA_WIDTH-1:0]     rs2_data;
    logic [REG_ADDR_WIDTH-1:0] rs1_addr;
    logic [REG_ADDR_WIDTH-1:0] rs2_addr;
    logic [REG_ADDR_WIDTH-1:0] rd_addr;
    logic                      use_pc;
    logic                      use_imm;
    logic                      rd_we;
  } id_ex_t;

  id_ex_t                 q;
  id_ex_t                 id_in;
  logic                   valid_q;
  logic [CNT_WIDTH-1:0]   stall_cnt_q;
  logic [DATA_WIDTH-1:0]  rs1_fwd;
  logic [DATA_WIDTH-1:0]  rs2_fwd;
  logic                   mem_hit1;
  logic                   mem_hit2;
  logic                   wb_hit1;
  logic                   wb_hit2;
  logic                   load_busy;
  logic                   hazard;
  logic                   accept;
  logic                   xfer;

  assign id_in = '{
    alu_op:   id_alu_op_i,
    pc:       id_pc_i,
    imm:      id_imm_i,
    rs1_data: id_rs1_data_i,
    rs2_data: id_rs2_data_i,
    rs1_addr: id_rs1_addr_i,
    rs2_addr: id_rs2_addr_i,
    rd_addr:  id_rd_addr_i,
    use_pc:   id_use_pc_i,
    use_imm:  id_use_imm_i,
    rd_we:    id_rd_we_i
  };

  assign mem_hit1 = mem_rd_we_i && mem_data_valid_i
                 && (q.rs1_addr != '0)
                 && (mem_rd_addr_i == q.rs1_addr);
  assign mem_hit2 = mem_rd_we_i && mem_data_valid_i
                 && (q.rs2_addr != '0)
                 && (mem_rd_addr_i == q.rs2_addr);
  assign wb_hit1  = wb_rd_we_i && (q.rs1_addr != '0)
                 && (wb_rd_addr_i == q.rs1_addr);
  assign wb_hit2  = wb_rd_we_i && (q.rs2_addr != '0)
                 && (wb_rd_addr_i == q.rs2_addr);

  // MEM is the younger producer, so it wins over WB
  always_comb begin
    rs1_fwd = q.rs1_data;
    rs2_fwd = q.rs2_data;
    if (mem_hit1)     rs1_fwd = mem_rd_data_i;
    else if (wb_hit1) rs1_fwd = wb_rd_data_i;
    if (mem_hit2)     rs2_fwd = mem_rd_data_i;
    else if (wb_hit2) rs2_fwd = wb_rd_data_i;
  end

  assign load_busy = valid_q && mem_rd_we_i
                  && !mem_data_valid_i
                  && (mem_rd_addr_i != '0);
  assign hazard = load_busy && (
      ((mem_rd_addr_i == q.rs1_addr) && !q.use_pc)
   || ((mem_rd_addr_i == q.rs2_addr) && !q.use_imm));

  assign ex_valid_o = valid_q && !hazard;
  assign xfer       = ex_valid_o && ex_ready_i;
  assign id_ready_o = !valid_q || xfer;
  assign accept     = id_valid_i && id_ready_o;

  assign alu_operator_o  = q.alu_op;
  assign alu_operand_a_o = q.use_pc  ? q.pc  : rs1_fwd;
  assign alu_operand_b_o = q.use_imm ? q.imm : rs2_fwd;
  assign ex_rd_addr_o    = q.rd_addr;
  assign ex_rd_we_o      = q.rd_we && ex_valid_o;
  assign stall_cnt_o     = stall_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q     <= 1'b0;
      q           <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (flush_i)     valid_q <= 1'b0;
      else if (accept) valid_q <= 1'b1;
      else if (xfer)   valid_q <= 1'b0;

      // refresh keeps forwarded values after the producer retires
      if (accept) begin
        q <= id_in;
      end else if (valid_q) begin
        q.rs1_data <= rs1_fwd;
        q.rs2_data <= rs2_fwd;
      end

      if (hazard && !flush_i && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_ex_operand_stage.sv
// Bench for ex_operand_stage: directed plan steps, then
// random traffic against an instruction-level reference model.
module tb_ex_operand_stage;
  import toothless_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, id_valid, id_ready;
  alu_opcode_e id_op, alu_op;
  logic [31:0] id_pc, id_imm, d1, d2;
  logic        upc, uimm, rd_we_in;
  logic [4:0]  a1, a2, rd_in;
  logic        mem_we, mem_dv, wb_we;
  logic [4:0]  mem_addr, wb_addr;
  logic [31:0] mem_data, wb_data;
  logic        ex_valid, ex_ready, ex_rd_we;
  logic [31:0] op_a, op_b, cnt;
  logic [4:0]  ex_rd;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ex_operand_stage dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .id_valid_i(id_valid), .id_ready_o(id_ready),
    .id_alu_op_i(id_op), .id_pc_i(id_pc), .id_imm_i(id_imm),
    .id_use_pc_i(upc), .id_use_imm_i(uimm),
    .id_rs1_addr_i(a1), .id_rs2_addr_i(a2),
    .id_rs1_data_i(d1), .id_rs2_data_i(d2),
    .id_rd_addr_i(rd_in), .id_rd_we_i(rd_we_in),
    .mem_rd_we_i(mem_we), .mem_rd_addr_i(mem_addr),
    .mem_rd_data_i(mem_data), .mem_data_valid_i(mem_dv),
    .wb_rd_we_i(wb_we), .wb_rd_addr_i(wb_addr),
    .wb_rd_data_i(wb_data),
    .ex_valid_o(ex_valid), .ex_ready_i(ex_ready),
    .alu_operator_o(alu_op),
    .alu_operand_a_o(op_a), .alu_operand_b_o(op_b),
    .ex_rd_addr_o(ex_rd), .ex_rd_we_o(ex_rd_we),
    .stall_cnt_o(cnt)
  );

  // reference: the one instruction sitting in EX, if any
  typedef struct packed {
    logic        v;
    alu_opcode_e op;
    logic [31:0] pc, imm, r1, r2;
    logic [4:0]  s1, s2, rd;
    logic        upc, uimm, we;
  } ins_t;

  ins_t        m;
  logic [31:0] m_cnt;

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // newest architectural value of register r
  function automatic logic [31:0] reg_val(
      logic [4:0] r, logic [31:0] held);
    if (r == 0) return held;
    if (mem_we && mem_dv && mem_addr == r) return mem_data;
    if (wb_we && wb_addr == r) return wb_data;
    return held;
  endfunction

  function automatic logic load_pending(logic [4:0] r);
    return mem_we && !mem_dv && mem_addr != 0
        && mem_addr == r;
  endfunction

  task automatic tick();
    logic stall, exv, rdy;
    ins_t n;
    #2;
    stall = m.v && ((!m.upc  && load_pending(m.s1))
                 || (!m.uimm && load_pending(m.s2)));
    exv = m.v && !stall;
    rdy = !m.v || (exv && ex_ready);
    chk("ex_valid", 32'(ex_valid), 32'(exv));
    chk("id_ready", 32'(id_ready), 32'(rdy));
    chk("rd_we",    32'(ex_rd_we), 32'(exv && m.we));
    chk("stall_cnt", cnt, m_cnt);
    if (exv) begin
      chk("operator", 32'(alu_op), 32'(m.op));
      chk("opa", op_a, m.upc ? m.pc : reg_val(m.s1, m.r1));
      chk("opb", op_b, m.uimm ? m.imm : reg_val(m.s2, m.r2));
      chk("rd", 32'(ex_rd), 32'(m.rd));
    end
    if (rst) begin
      m = '0;
      m_cnt = 0;
    end else begin
      if (stall && !flush && m_cnt != 32'hFFFF_FFFF)
        m_cnt++;
      n = m;
      n.r1 = reg_val(m.s1, m.r1);
      n.r2 = reg_val(m.s2, m.r2);
      if (flush) n.v = 1'b0;
      else if (id_valid && rdy)
        n = '{1'b1, id_op, id_pc, id_imm, d1, d2,
              a1, a2, rd_in, upc, uimm, rd_we_in};
      else if (exv && ex_ready) n.v = 1'b0;
      if (!(id_valid && rdy) || flush) m = n;
      else m = n;
    end
    @(negedge clk);
  endtask

  task automatic offer(alu_opcode_e op, logic [31:0] pc,
                       logic [31:0] imm, logic up, logic ui,
                       logic [4:0] s1, logic [31:0] v1,
                       logic [4:0] s2, logic [31:0] v2,
                       logic [4:0] rd);
    id_valid = 1; id_op = op; id_pc = pc; id_imm = imm;
    upc = up; uimm = ui; a1 = s1; d1 = v1;
    a2 = s2; d2 = v2; rd_in = rd; rd_we_in = 1;
  endtask

  initial begin
    rst = 1; flush = 0; id_valid = 0; ex_ready = 1;
    id_op = ALU_ADD; id_pc = 0; id_imm = 0;
    upc = 0; uimm = 0; a1 = 0; a2 = 0; d1 = 0; d2 = 0;
    rd_in = 0; rd_we_in = 0;
    mem_we = 0; mem_dv = 1; mem_addr = 0; mem_data = 0;
    wb_we = 0; wb_addr = 0; wb_data = 0;
    m = '0; m_cnt = 0;
    @(negedge clk);
    tick();
    tick();
    rst = 0;
    #1;
    chk("rst_valid", 32'(ex_valid), 0);
    chk("rst_rdwe", 32'(ex_rd_we), 0);
    chk("rst_op", 32'(alu_op), 32'(ALU_ADD));
    chk("rst_a", op_a, 0);
    chk("rst_b", op_b, 0);
    chk("rst_cnt", cnt, 0);

    offer(ALU_ADD, 32'h100, 0, 0, 0, 1, 5, 2, 7, 6);
    tick();
    offer(ALU_ADD, 32'h104, 0, 0, 0, 3, 0, 0, 0, 7);
    #1;
    chk("add_valid", 32'(ex_valid), 1);
    chk("add_op", 32'(alu_op), 32'(ALU_ADD));
    chk("add_a", op_a, 5);
    chk("add_b", op_b, 7);
    tick();

    id_valid = 0; ex_ready = 0;
    mem_we = 1; mem_addr = 3; mem_data = 32'h10; mem_dv = 1;
    wb_we = 1; wb_addr = 3; wb_data = 32'h20;
    #1 chk("fwd_mem", op_a, 32'h10);
    tick();
    mem_we = 0;
    #1 chk("fwd_wb", op_a, 32'h20);
    tick();

    wb_we = 0; ex_ready = 1;
    offer(ALU_OR, 32'h108, 0, 0, 0, 0, 0, 4, 0, 8);
    tick();
    ex_ready = 0;
    offer(ALU_XOR, 32'h10c, 0, 0, 0, 1, 1, 2, 2, 9);
    wb_we = 1; wb_addr = 4; wb_data = 32'h55;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_b", op_b, 32'h55);
      chk("hold_rdy", 32'(id_ready), 0);
      tick();
      wb_we = 0;
    end

    ex_ready = 1;
    offer(ALU_ADD, 32'h400, 32'h8, 1, 1, 5, 0, 5, 0, 10);
    tick();
    mem_we = 1; mem_addr = 5; mem_dv = 0; mem_data = 32'h99;
    offer(ALU_SUB, 32'h110, 0, 0, 0, 5, 1, 0, 3, 11);
    #1;
    chk("nostall_valid", 32'(ex_valid), 1);
    chk("nostall_cnt", cnt, 0);
    tick();
    id_valid = 0;
    for (int i = 0; i < 2; i++) begin
      #1 chk("lu_bubble", 32'(ex_valid), 0);
      tick();
    end
    mem_dv = 1;
    #1;
    chk("lu_valid", 32'(ex_valid), 1);
    chk("lu_a", op_a, 32'h99);
    chk("lu_b", op_b, 3);
    chk("lu_cnt", cnt, 2);
    tick();
    mem_we = 0;

    offer(ALU_AND, 32'h114, 0, 0, 0, 1, 1, 2, 2, 12);
    tick();
    ex_ready = 0;
    offer(ALU_SLL, 32'h118, 0, 0, 0, 1, 1, 2, 2, 13);
    flush = 1;
    tick();
    flush = 0; id_valid = 0;
    #1 chk("flush_valid", 32'(ex_valid), 0);
    tick();

    offer(ALU_SRL, 32'h11c, 0, 0, 0, 2, 1, 0, 0, 14);
    tick();
    id_valid = 0;
    mem_we = 1; mem_addr = 2; mem_dv = 0;
    tick();
    tick();
    rst = 1;
    tick();
    rst = 0; mem_we = 0;
    #1;
    chk("mrst_valid", 32'(ex_valid), 0);
    chk("mrst_cnt", cnt, 0);
    tick();

    for (int i = 0; i < 400; i++) begin
      offer(alu_opcode_e'($urandom_range(0, 9)),
            $urandom, $urandom,
            1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 3) == 0),
            5'($urandom_range(0, 3)), $urandom,
            5'($urandom_range(0, 3)), $urandom,
            5'($urandom_range(0, 31)));
      rd_we_in = 1'($urandom);
      id_valid = 1'($urandom_range(0, 3) != 0);
      ex_ready = 1'($urandom_range(0, 3) != 0);
      flush    = 1'($urandom_range(0, 15) == 0);
      rst      = 1'($urandom_range(0, 63) == 0);
      mem_we   = 1'($urandom);
      mem_addr = 5'($urandom_range(0, 3));
      mem_data = $urandom;
      mem_dv   = 1'($urandom_range(0, 2) != 0);
      wb_we    = 1'($urandom);
      wb_addr  = 5'($urandom_range(0, 3));
      wb_data  = $urandom;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
- ID/EX pipeline register directly upstream of the ALU.
- Captures a decoded instruction, selects and forwards operands, and drives operator/operand_a/operand_b straight into the ALU.
- Detects load-use hazards and inserts bubbles; supports valid/ready backpressure and flush.

Parameters:
- DATA_WIDTH, 32, operand/PC/immediate width
- REG_ADDR_WIDTH, 5, register index width
- CNT_WIDTH, 32, stall counter width

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  synchronous, active-high reset
- flush_i  in  1  kill held/incoming instruction (branch/trap)
- id_valid_i  in  1  decode offers an instruction
- id_ready_o  out  1  stage accepts this cycle
- id_alu_op_i  in  alu_opcode_e  ALU operator (toothless_pkg)
- id_pc_i  in  DATA_WIDTH  instruction PC
- id_imm_i  in  DATA_WIDTH  sign-extended immediate
- id_use_pc_i  in  1  operand_a = PC instead of rs1
- id_use_imm_i  in  1  operand_b = imm instead of rs2
- id_rs1_addr_i, id_rs2_addr_i  in  REG_ADDR_WIDTH  source indices
- id_rs1_data_i, id_rs2_data_i  in  DATA_WIDTH  register-file read data
- id_rd_addr_i  in  REG_ADDR_WIDTH  destination index
- id_rd_we_i  in  1  instruction writes rd
- mem_rd_we_i  in  1  EX/MEM holds a register-writing instruction
- mem_rd_addr_i  in  REG_ADDR_WIDTH  its rd
- mem_rd_data_i  in  DATA_WIDTH  its result
- mem_data_valid_i  in  1  result available (0 for load in flight)
- wb_rd_we_i  in  1  writeback writes register file this cycle
- wb_rd_addr_i  in  REG_ADDR_WIDTH  writeback rd
- wb_rd_data_i  in  DATA_WIDTH  writeback data
- ex_valid_o  out  1  ALU inputs valid
- ex_ready_i  in  1  downstream accepts
- alu_operator_o  out  alu_opcode_e  to ALU operator_i
- alu_operand_a_o, alu_operand_b_o  out  DATA_WIDTH  to ALU operands
- ex_rd_addr_o  out  REG_ADDR_WIDTH  registered rd
- ex_rd_we_o  out  1  registered rd write enable (gated by ex_valid_o)
- stall_cnt_o  out  CNT_WIDTH  count of hazard bubble cycles

Behaviour:
- Reset (rst_i=1 at edge): valid_q=0, all payload registers 0, stall_cnt_o=0. Outputs: ex_valid_o=0, ex_rd_we_o=0, alu_operator_o=ALU_ADD, operands 0. Reset mid-transfer discards the held instruction.
- Forwarding (combinational on held rs data, per source): if mem_rd_we_i && mem_rd_addr_i==rs && rs!=0 && mem_data_valid_i, use mem_rd_data_i. Else if wb_rd_we_i && wb_rd_addr_i==rs && rs!=0, use wb_rd_data_i. Else use the held value. MEM has priority over WB. x0 is never forwarded.
- Hazard: valid_q && mem_rd_we_i && !mem_data_valid_i && mem_rd_addr_i!=0. Plus rs1 match with !use_pc_q, or rs2 match with !use_imm_q.
- operand_a = use_pc_q ? pc_q : rs1_fwd. operand_b = use_imm_q ? imm_q : rs2_fwd. Operator passes through from the register.
- ex_valid_o = valid_q && !hazard. id_ready_o = !valid_q || (ex_valid_o && ex_ready_i). Combinational; no ID->ALU bypass; latency is exactly 1 cycle from acceptance.
- Capture: on id_valid_i && id_ready_o, load all payload and set valid_q=1. Else if transfer (ex_valid_o && ex_ready_i), clear valid_q.
- Refresh while holding: valid_q && !(id_valid_i && id_ready_o). Each cycle, rs1/rs2 data regs load rs1_fwd/rs2_fwd so forwarded values persist after the producer retires.
- Flush: valid_q is 0 next cycle and the incoming instruction is dropped (id_ready_o may be 1; the accepted instruction is discarded). Flush overrides capture and hazard.
- Simultaneous transfer-out and capture: back-to-back, no bubble.
- stall_cnt_o increments by 1 each cycle hazard=1 and flush_i=0. Saturates at all-ones.

Test Plan:
- Reset, then ADD rs1=x1(5), rs2=x2(7), no forward, ex_ready_i=1 -> next cycle ex_valid_o=1, operator=ALU_ADD, a=5, b=7. ID takes a new instruction every cycle.
- Held rs1=x3 data 0. mem_rd_we=1, addr=3, data=0x10, valid=1, with wb also writing x3=0x20 -> a=0x10. Drop mem forward -> a=0x20.
- ex_ready_i=0 for 3 cycles. WB writes x4=0x55 only in cycle 1 for held rs2=x4 -> b stays 0x55 through cycle 3. id_ready_o=0 throughout.
- Load in MEM (rd=x5, data_valid=0) for 2 cycles, held SUB rs1=x5 -> ex_valid_o=0 for 2 cycles, stall_cnt_o=2. Valid rises with a=mem data.
- Same load hazard but held instruction uses use_pc=1, use_imm=1 -> no stall, stall_cnt_o stays 0.
- flush_i with id_valid_i=1 and valid_q=1 -> next cycle ex_valid_o=0. Mid-stream rst_i -> ex_valid_o=0, stall_cnt_o=0.
